axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  Bridges a simple single-outstanding CPU memory request port (IFU/LSU side) to an AXI-lite master interface.
//  Drives the AR/R and AW/W/B channels of any AXI-lite slave on the bus (SRAM, UART, CLINT).
//  One transaction in flight at a time; read and write are mutually exclusive.
// PARAMETERS
//  none (address/data/strobe/resp widths come from `AXI_ADDR_BUS, `AXI_DATA_BUS, `AXI_WSTRB_BUS, `AXI_RESP_BUS in defines.svh)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   CPU request valid
//  req_ready  out  1   request accepted when valid&&ready
//  req_we     in   1   1=write, 0=read
//  req_addr   in   32  byte address, forwarded unmodified
//  req_wdata  in   32  write data
//  req_wstrb  in   4   byte enables
//  rsp_valid  out  1   response valid
//  rsp_ready  in   1   CPU accepts response
//  rsp_rdata  out  32  read data (write: holds last value)
//  rsp_err    out  1   non-OKAY response (see CONFIGURATION)
//  araddr/arvalid out, arready in; rdata/rresp/rvalid in, rready out;
//  awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out  (AXI-lite widths)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; arvalid=awvalid=wvalid=rready=bready=0; rsp_valid=0; rsp_rdata=`INST_NOP; rsp_err=0; aw_done=w_done=0.
//  FSM states: IDLE, AR, R, WR (AW+W), B, RSP.
//  IDLE: req_ready=1 (combinational on state only). On req handshake latch addr/wdata/wstrb; we=0 -> AR, we=1 -> WR.
//  AR: arvalid=1, araddr=latched addr; on arready -> R. arvalid never drops before handshake.
//  R: rready=1; on rvalid capture rdata (and rresp) -> RSP.
//  WR: awvalid=!aw_done, wvalid=!w_done, both raised same cycle; each flag set on its own handshake, in any order or together;
//      when both done (incl. same-cycle) -> B; flags cleared on exit.
//  B: bready=1; on bvalid capture bresp -> RSP.
//  RSP: rsp_valid=1, data/err stable until rsp_ready; then -> IDLE (next req accepted the cycle after).
//  Latency with zero-wait slave: req handshake cycle 0, arvalid cycle 1, rvalid earliest cycle 2, rsp_valid cycle 3.
//  Master outputs are pure functions of registered state/flags; no combinational path from slave *ready/*valid to master *valid.
//  Never asserts arvalid and awvalid simultaneously. wstrb=0 write still issued. No alignment check.
//  Reset mid-transaction: all valids/readies 0 at next edge, transaction dropped, no rsp_valid issued; slave reset in same domain.
//  Illegal state encoding -> IDLE.
// CONFIGURATION
//  `AXI_MASTER_RESP_CHECK_EN defined: rsp_err = (captured rresp/bresp != 2'b00), valid with rsp_valid.
//  Undefined: rresp/bresp ignored, rsp_err tied 0, no resp capture register.
// STRUCTURE
//  axi_pkg: state enum (IDLE..RSP), AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
//  Flat module; no sub-module (FSM + latch regs only).
// TESTING
//  Read, slave with LFSR delay 0..7 returning 0xDEADBEEF @0x8000_0000 -> one arvalid handshake, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  Write 0x1234_5678 wstrb=4'b0011 @0x8000_0010, awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, single bvalid, rsp_valid 1 cycle.
//  Write with awready&&wready same cycle -> WR->B in one cycle; memory shows 0x5678 in low half only.
//  rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
//  RESP_CHECK_EN, slave rresp=2'b10 -> rsp_err=1 with rsp_valid; macro off -> rsp_err=0.
//  rst_n=0 while arvalid high and arready=0 -> next cycle arvalid=0, state IDLE, no rsp_valid.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI-lite constants and FSM state encodings for axi_lite_master.
// Supplies default bus-width macros when defines.svh has not provided them.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS 3:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_RSP  = 3'd5;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding CPU request port to AXI-lite master bridge (AR/R and AW/W/B).
// Optional AXI_MASTER_RESP_CHECK_EN: reports non-OKAY rresp/bresp on rsp_err.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS 3:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module axi_lite_master
  import axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [`AXI_ADDR_BUS]  req_addr,
  input  logic [`AXI_DATA_BUS]  req_wdata,
  input  logic [`AXI_WSTRB_BUS] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [`AXI_DATA_BUS]  rsp_rdata,
  output logic                  rsp_err,
  output logic [`AXI_ADDR_BUS]  araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [`AXI_DATA_BUS]  rdata,
  input  logic [`AXI_RESP_BUS]  rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [`AXI_ADDR_BUS]  awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [`AXI_DATA_BUS]  wdata,
  output logic [`AXI_WSTRB_BUS] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [`AXI_RESP_BUS]  bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [`AXI_ADDR_BUS]  r_addr;
  logic [`AXI_DATA_BUS]  r_wdata;
  logic [`AXI_WSTRB_BUS] r_wstrb;
  logic [`AXI_DATA_BUS]  r_rdata;

  logic w_req_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_wr_exit;

  // Every master-side valid/ready decodes only from registered state and flags.
  assign req_ready = (r_state == ST_IDLE);
  assign arvalid   = (r_state == ST_AR);
  assign rready    = (r_state == ST_R);
  assign awvalid   = (r_state == ST_WR) && !r_aw_done;
  assign wvalid    = (r_state == ST_WR) && !r_w_done;
  assign bready    = (r_state == ST_B);
  assign rsp_valid = (r_state == ST_RSP);

  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign rsp_rdata = r_rdata;

  assign w_req_hs  = req_valid && req_ready;
  assign w_aw_hs   = awvalid && awready;
  assign w_w_hs    = wvalid && wready;
  assign w_aw_fin  = r_aw_done || w_aw_hs;
  assign w_w_fin   = r_w_done || w_w_hs;
  assign w_wr_exit = (r_state == ST_WR) && w_aw_fin && w_w_fin;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = req_we ? ST_WR : ST_AR;
      ST_AR:   if (arready)   w_state_nxt = ST_R;
      ST_R:    if (rvalid)    w_state_nxt = ST_RSP;
      ST_WR:   if (w_wr_exit) w_state_nxt = ST_B;
      ST_B:    if (bvalid)    w_state_nxt = ST_RSP;
      ST_RSP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= `INST_NOP;
    end else begin
      r_state <= w_state_nxt;
      // Channel-done flags live only while in WR; leaving WR clears both.
      if ((r_state == ST_WR) && !w_wr_exit) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if ((r_state == ST_R) && rvalid) r_rdata <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

`ifdef AXI_MASTER_RESP_CHECK_EN
  logic [`AXI_RESP_BUS] r_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp <= AXI_RESP_OKAY;
    end else if ((r_state == ST_R) && rvalid) begin
      r_resp <= rresp;
    end else if ((r_state == ST_B) && bvalid) begin
      r_resp <= bresp;
    end
  end

  assign rsp_err = resp_is_err(r_resp);
`else
  logic w_unused_resp;

  assign w_unused_resp = ^{rresp, bresp};
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a hand-driven AXI-lite slave and small word memory.
// Expected rsp_err follows AXI_MASTER_RESP_CHECK_EN.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

`ifdef AXI_MASTER_RESP_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n_ar_hs = 0;
  int n_aw_hs = 0;
  int n_w_hs = 0;
  int n_b_hs = 0;
  int n_overlap = 0;

  logic [31:0] mem [0:15];
  logic [7:0]  lfsr = 8'hA5;

  axi_lite_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) n_ar_hs <= n_ar_hs + 1;
    if (awvalid && awready) n_aw_hs <= n_aw_hs + 1;
    if (wvalid && wready)   n_w_hs  <= n_w_hs + 1;
    if (bvalid && bready)   n_b_hs  <= n_b_hs + 1;
    if (arvalid && awvalid) n_overlap <= n_overlap + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input logic [1:0] resp, input int hold,
                          input logic [31:0] exp_data, input logic exp_err);
    int ar0;
    logic [31:0] a;
    ar0 = n_ar_hs;
    chk1("rd_req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < ar_dly; c++) begin
      chk1("rd_arvalid_held", arvalid, 1'b1);
      chk32("rd_araddr_held", araddr, addr);
      tick();
    end
    chk1("rd_arvalid", arvalid, 1'b1);
    chk32("rd_araddr", araddr, addr);
    chk1("rd_no_awvalid", awvalid, 1'b0);
    a = araddr;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk1("rd_arvalid_drop", arvalid, 1'b0);
    for (int c = 0; c < r_dly; c++) begin
      chk1("rd_rready_wait", rready, 1'b1);
      tick();
    end
    chk1("rd_rready", rready, 1'b1);
    chk1("rd_rsp_not_early", rsp_valid, 1'b0);
    rvalid = 1'b1; rdata = mem[a[5:2]]; rresp = resp;
    tick();
    rvalid = 1'b0; rdata = 32'h0BAD_0BAD; rresp = 2'b00;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rsp_rdata", rsp_rdata, exp_data);
    chk1("rd_rsp_err", rsp_err, exp_err);
    chk1("rd_rready_drop", rready, 1'b0);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk1("rd_hold_rsp_valid", rsp_valid, 1'b1);
      chk32("rd_hold_rsp_rdata", rsp_rdata, exp_data);
      chk1("rd_hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("rd_rsp_done", rsp_valid, 1'b0);
    chk1("rd_back_idle", req_ready, 1'b1);
    chk32("rd_ar_handshakes", 32'(n_ar_hs - ar0), 32'd1);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] resp,
                           input logic exp_err);
    int aw0, w0, b0, last;
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b_hs;
    wa = '0; wd = '0; ws = '0;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    chk1("wr_req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_wstrb = strb;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c <= last; c++) begin
      chk1("wr_awvalid", awvalid, (c <= aw_dly));
      chk1("wr_wvalid", wvalid, (c <= w_dly));
      chk1("wr_no_arvalid", arvalid, 1'b0);
      chk1("wr_no_bready", bready, 1'b0);
      if (c == aw_dly) begin
        wa = awaddr;
        chk32("wr_awaddr", awaddr, addr);
      end
      if (c == w_dly) begin
        wd = wdata; ws = wstrb;
        chk32("wr_wdata", wdata, data);
        chk32("wr_wstrb", {28'd0, wstrb}, {28'd0, strb});
      end
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) mem[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
    end
    chk1("wr_b_awvalid", awvalid, 1'b0);
    chk1("wr_b_wvalid", wvalid, 1'b0);
    chk1("wr_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk1("wr_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_rsp_err", rsp_err, exp_err);
    chk1("wr_bready_drop", bready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("wr_rsp_done", rsp_valid, 1'b0);
    chk32("wr_aw_handshakes", 32'(n_aw_hs - aw0), 32'd1);
    chk32("wr_w_handshakes", 32'(n_w_hs - w0), 32'd1);
    chk32("wr_b_handshakes", 32'(n_b_hs - b0), 32'd1);
  endtask

  initial begin
    int d_ar, d_r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0; arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hAAAA_AAAA;
    mem[0] = 32'hDEAD_BEEF;
    mem[5] = 32'h1111_2222;
    mem[6] = 32'h5555_6666;

    tick();
    tick();
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0000_0013);
    rst_n = 1'b1;
    tick();

    cpu_read(32'h8000_0000, 0, 0, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      d_ar = int'(lfsr[2:0]);
      d_r  = int'(lfsr[5:3]);
      cpu_read(32'h8000_0000, d_ar, d_r, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);
    end

    cpu_write(32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 3, 2'b00, 1'b0);
    cpu_read(32'h8000_0010, 0, 0, 2'b00, 0, 32'hAAAA_5678, 1'b0);

    cpu_write(32'h8000_0014, 32'hCAFE_F00D, 4'b1100, 0, 0, 2'b00, 1'b0);
    cpu_read(32'h8000_0014, 1, 0, 2'b00, 0, 32'hCAFE_2222, 1'b0);

    cpu_write(32'h8000_0018, 32'h0102_0304, 4'b1111, 2, 0, 2'b00, 1'b0);
    cpu_read(32'h8000_0018, 0, 2, 2'b00, 0, 32'h0102_0304, 1'b0);

    cpu_write(32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 1, 1, 2'b00, 1'b0);
    cpu_read(32'h8000_0000, 0, 0, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);

    cpu_read(32'h8000_0014, 0, 0, 2'b00, 5, 32'hCAFE_2222, 1'b0);

    cpu_read(32'h8000_0000, 0, 1, 2'b10, 0, 32'hDEAD_BEEF, ERR_ON);
    cpu_read(32'h8000_0018, 0, 0, 2'b00, 0, 32'h0102_0304, 1'b0);
    cpu_write(32'h8000_001C, 32'h7777_8888, 4'b1111, 0, 0, 2'b11, ERR_ON);

    // Reset while arvalid is pending with no arready.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0000;
    tick();
    req_valid = 1'b0;
    chk1("mid_arvalid_up", arvalid, 1'b1);
    tick();
    chk1("mid_arvalid_still", arvalid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("mid_arvalid_cleared", arvalid, 1'b0);
    chk1("mid_rsp_valid", rsp_valid, 1'b0);
    chk1("mid_req_ready", req_ready, 1'b1);
    chk32("mid_rsp_rdata", rsp_rdata, 32'h0000_0013);
    rst_n = 1'b1;
    tick();
    tick();
    chk1("mid_post_rsp_valid", rsp_valid, 1'b0);
    chk1("mid_post_arvalid", arvalid, 1'b0);
    cpu_read(32'h8000_0000, 0, 0, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);

    chk32("no_ar_aw_overlap", 32'(n_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
